pattern_scan_ctrl: RTL and testbench
====================================

# pattern_scan_ctrl

- Word-level controller that sequences a serial "1000" Moore sequence detector.
- Accepts parallel words over a valid/ready handshake and feeds them to the detector MSB first, one bit per clock.
- Holds the detector in reset between words and counts detector hits per word.
- Returns the per-word result over a second valid/ready handshake; sits between the word source and the detector instance.

## Interface
Parameters:
- WORD_W, 8, bits per input word; legal range WORD_W ≥ 4
- CNT_W, 4, width of the hit counter; count saturates at 2^CNT_W−1

Ports:
- clock  input  1  single clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high; returns the block to IDLE
- in_valid  input  1  input word offered
- in_data  input  WORD_W  word to scan; bit WORD_W−1 is presented first
- in_ready  output  1  block can accept a word
- det_seq_in  output  1  serial bit to the detector's data input
- det_reset  output  1  registered reset to the detector; high = detector held in its initial state
- det_hit  input  1  detector's Moore match output
- out_valid  output  1  result available
- out_count  output  CNT_W  number of hits in the word (saturating)
- out_hit  output  1  high if out_count ≠ 0
- out_ready  input  1  consumer accepts the result
- out_first_pos  output  $clog2(WORD_W)  present only with PSC_POS_EN; see Configuration

## Operation
- **States:** IDLE, SHIFT, DRAIN, DONE, held in a registered state variable.
- **IDLE**
  - in_ready=1, det_reset=1, det_seq_in=0.
  - On in_valid && in_ready: latch in_data into a shift register, clear the bit index and the count, go to SHIFT.
- **SHIFT** (WORD_W cycles, bit index k = 0..WORD_W−1)
  - det_seq_in = shift register MSB; shift left by one each cycle.
  - det_reset=0.
  - After k = WORD_W−1, go to DRAIN.
- **DRAIN** (1 cycle)
  - det_reset=0, det_seq_in=0.
  - Samples the detector's response to the last bit, then goes to DONE.
- **Hit counting**
  - det_hit is sampled in SHIFT cycles k = 1..WORD_W−1 and in the DRAIN cycle.
  - A hit sampled in cycle k+1 is attributed to bit k; the DRAIN cycle counts as k = WORD_W.
  - Each sampled 1 increments count; count saturates at 2^CNT_W−1 with no wrap.
  - det_hit is ignored in IDLE, DONE and SHIFT cycle k=0.
- **DONE**
  - out_valid=1 and det_reset=1.
  - out_count, out_hit and out_first_pos stay stable until out_valid && out_ready, then the block goes to IDLE.
- **No cross-word matching:** the detector is reset before every word, so a pattern spanning two words is never counted.
- in_valid and in_data are ignored outside IDLE.
- Reset in any state:
  - the next state is IDLE, count=0 and out_valid=0;
  - det_reset=1 is registered, so the detector is forced to its initial state;
  - any in-flight word is discarded with no output.

## Timing
- Values in the cycle after reset is sampled: in_ready=1, out_valid=0, out_count=0, out_hit=0, det_reset=1, det_seq_in=0, out_first_pos=0.
- in_ready and out_valid are decoded from the registered state (glitch-free, no combinational path from inputs).
- det_reset is a flop output because the detector's reset is asynchronous.
- It falls on the same edge that enters SHIFT and rises on the edge that enters DONE.
- Word accepted in cycle c0:
  - SHIFT occupies c1..c(WORD_W), DRAIN is c(WORD_W+1), out_valid rises in c(WORD_W+2).
  - Latency is WORD_W+2 cycles.
- With out_ready held high: DONE lasts 1 cycle, in_ready returns in c(WORD_W+3), and throughput is one word per WORD_W+3 cycles.

## Configuration
- **Macro PSC_POS_EN, defined:**
  - Adds out_first_pos, a register capturing the index k (0 = MSB) of the bit that completed the first hit in the word.
  - Written only on the first counted hit, cleared at word acceptance, held through DONE.
  - Reads 0 when out_hit=0.
- **Macro PSC_POS_EN, undefined:** the port and its register are absent; all other behaviour is identical.

## Test plan
- **Single hit:** accept 8'b1000_0000, out_ready=1 → out_valid in c10, out_count=1, out_hit=1, out_first_pos=3. During c1..c8, det_seq_in = 1,0,0,0,0,0,0,0.
- **Two hits and a late hit:**
  - 8'b1000_1000 → out_count=2, out_first_pos=3.
  - 8'b0001_0000 → out_count=1, out_first_pos=6.
  - 8'hFF → out_count=0, out_hit=0.
- **Backpressure:** out_ready low for 5 cycles after out_valid → out_valid, out_count and out_hit stay stable, in_ready=0, det_reset=1. Raise out_ready → in_ready=1 the following cycle.
- **No cross-word match:** words 8'b0000_0001 then 8'h00 → both out_count=0.
- **Reset mid-operation:** assert reset during SHIFT k=2 of 8'h80 → no out_valid. The next cycle shows in_ready=1 and det_reset=1. A following 8'h80 gives out_count=1.
- **Saturation:** CNT_W=1, word 8'b1000_1000 → out_count=1, out_hit=1 (no wrap to 0).

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// Word-level sequencer for a serial "1000" Moore detector: shifts each word out MSB first,
// counts detector hits per word and returns the count. Optional macro PSC_POS_EN adds out_first_pos.
module pattern_scan_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              det_seq_in,
    output logic              det_reset,
    input  logic              det_hit,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_hit,
    input  logic              out_ready
`ifdef PSC_POS_EN
    ,
    output logic [$clog2(WORD_W)-1:0] out_first_pos
`endif
);
    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [WORD_W-1:0] shift_reg, shift_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              det_reset_reg;
    logic              hit_sample;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            idx_reg       <= '0;
            count_reg     <= '0;
            det_reset_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            idx_reg       <= idx_next;
            count_reg     <= count_next;
            // Detector reset is asynchronous, so it must come straight from a flop.
            det_reset_reg <= (state_next == IDLE) || (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        idx_next   = idx_reg;
        count_next = count_reg;
        hit_sample = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = SHIFT;
                    shift_next = in_data;
                    idx_next   = '0;
                    count_next = '0;
                end
            end
            SHIFT: begin
                shift_next = {shift_reg[WORD_W-2:0], 1'b0};
                idx_next   = idx_reg + IDX_W'(1);
                // Moore output lags one cycle: at k=0 it still reflects the reset state.
                hit_sample = det_hit && (idx_reg != '0);
                if (idx_reg == LAST_IDX) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                hit_sample = det_hit;
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (hit_sample && (count_reg != CNT_MAX)) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

`ifdef PSC_POS_EN
    logic [IDX_W-1:0] pos_reg;

    // A hit seen in sampling cycle k belongs to bit k-1; DRAIN belongs to the last bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            pos_reg <= '0;
        end else if ((state_reg == IDLE) && in_valid) begin
            pos_reg <= '0;
        end else if (hit_sample && (count_reg == '0)) begin
            pos_reg <= (state_reg == DRAIN) ? LAST_IDX : (idx_reg - IDX_W'(1));
        end
    end

    assign out_first_pos = pos_reg;
`endif

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign det_reset  = det_reset_reg;
    assign det_seq_in = (state_reg == SHIFT) && shift_reg[WORD_W-1];
    assign out_count  = count_reg;
    assign out_hit    = (count_reg != '0);

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: two DUTs (CNT_W=4 and CNT_W=1) share stimulus, each driving
// its own "1000" Moore detector; results are compared with a substring-count reference.
`timescale 1ns/1ps
module tb_pattern_scan_ctrl;
    localparam int W  = 8;
    localparam int PW = $clog2(W);

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic         in_ready, det_seq_in, det_reset, det_hit, out_valid, out_hit;
    logic [3:0]   out_count;
    logic         s_in_ready, s_det_seq_in, s_det_reset, s_det_hit, s_out_valid, s_out_hit;
    logic [0:0]   s_out_count;
`ifdef PSC_POS_EN
    logic [PW-1:0] out_first_pos, s_out_first_pos;
`endif

    pattern_scan_ctrl #(.WORD_W(W), .CNT_W(4)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .det_seq_in(det_seq_in), .det_reset(det_reset),
        .det_hit(det_hit), .out_valid(out_valid), .out_count(out_count),
        .out_hit(out_hit), .out_ready(out_ready)
`ifdef PSC_POS_EN
        , .out_first_pos(out_first_pos)
`endif
    );

    pattern_scan_ctrl #(.WORD_W(W), .CNT_W(1)) u_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .det_seq_in(s_det_seq_in), .det_reset(s_det_reset),
        .det_hit(s_det_hit), .out_valid(s_out_valid), .out_count(s_out_count),
        .out_hit(s_out_hit), .out_ready(out_ready)
`ifdef PSC_POS_EN
        , .out_first_pos(s_out_first_pos)
`endif
    );

    // External detector: number of pattern bits matched so far; 4 = "1000" seen.
    function automatic int det_next(input int st, input logic b);
        if (b) return 1;
        if (st == 1) return 2;
        if (st == 2) return 3;
        if (st == 3) return 4;
        return 0;
    endfunction

    int det_st = 0, s_det_st = 0;
    always @(posedge clock or posedge det_reset)
        if (det_reset) det_st <= 0; else det_st <= det_next(det_st, det_seq_in);
    always @(posedge clock or posedge s_det_reset)
        if (s_det_reset) s_det_st <= 0; else s_det_st <= det_next(s_det_st, s_det_seq_in);
    assign det_hit   = (det_st == 4);
    assign s_det_hit = (s_det_st == 4);

    // Reference: count "1000" substrings inside the word, MSB first; position = index of final 0.
    function automatic int ref_hits(input logic [W-1:0] w);
        int n = 0;
        for (int i = 0; i + 3 < W; i++)
            if (w[W-1-i] && !w[W-2-i] && !w[W-3-i] && !w[W-4-i]) n++;
        return n;
    endfunction

    function automatic int ref_first(input logic [W-1:0] w);
        for (int i = 0; i + 3 < W; i++)
            if (w[W-1-i] && !w[W-2-i] && !w[W-3-i] && !w[W-4-i]) return i + 3;
        return 0;
    endfunction

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int           obs_lat, obs_acc;
    logic [W-1:0] obs_seq;
    logic         obs_drlow, obs_dr_done, obs_hit, obs_shit, obs_bp_ok, obs_rdy_after, obs_ov_after;
    logic [3:0]   obs_cnt;
    logic [0:0]   obs_scnt;
    logic [PW-1:0] obs_pos, obs_spos;

    task automatic run_word(input logic [W-1:0] w, input int hold);
        int n;
        in_valid = 1'b1; in_data = w; out_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < 40) begin @(posedge clock); #1; n++; end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
        end
        obs_acc = cyc;
        @(posedge clock); #1;
        in_valid = 1'b0; in_data = '0;
        obs_lat = 1; obs_seq = '0; obs_drlow = 1'b1;
        while (!out_valid && obs_lat < 40) begin
            if (obs_lat <= W) obs_seq[W - obs_lat] = det_seq_in;
            if (det_reset) obs_drlow = 1'b0;
            @(posedge clock); #1; obs_lat++;
        end
        if (!out_valid) begin
            total++; bad++;
            $display("FAIL out_valid_timeout out_valid=%b required=1", out_valid);
        end
        obs_cnt = out_count; obs_hit = out_hit; obs_scnt = s_out_count; obs_shit = s_out_hit;
        obs_dr_done = det_reset;
        obs_pos = '0; obs_spos = '0;
`ifdef PSC_POS_EN
        obs_pos = out_first_pos; obs_spos = s_out_first_pos;
`endif
        obs_bp_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            if (!out_valid || in_ready || !det_reset || out_count !== obs_cnt || out_hit !== obs_hit)
                obs_bp_ok = 1'b0;
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        obs_rdy_after = in_ready; obs_ov_after = out_valid;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_count !== 4'd0 || out_hit !== 1'b0) begin bad++; $display("FAIL reset_count got=%0d/%b exp=0/0", out_count, out_hit); end
        total++; if (det_reset !== 1'b1 || det_seq_in !== 1'b0) begin bad++; $display("FAIL reset_det got=%b/%b exp=1/0", det_reset, det_seq_in); end
`ifdef PSC_POS_EN
        total++; if (out_first_pos !== '0) begin bad++; $display("FAIL reset_pos got=%0d exp=0", out_first_pos); end
`endif
        reset = 1'b0;
        @(posedge clock); #1;
        $display("test_reset done");
    endtask

    task automatic test_single_hit;
        run_word(8'h80, 0);
        $display("word=%h lat=%0d seq=%b count=%0d", 8'h80, obs_lat, obs_seq, obs_cnt);
        total++; if (obs_lat != W + 2) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", obs_lat, W + 2); end
        total++; if (obs_seq !== 8'h80) begin bad++; $display("FAIL single_seq got=%b exp=%b", obs_seq, 8'h80); end
        total++; if (obs_drlow !== 1'b1 || obs_dr_done !== 1'b1) begin bad++; $display("FAIL single_det_reset low=%b done=%b exp=1/1", obs_drlow, obs_dr_done); end
        total++; if (obs_cnt !== 4'd1 || obs_hit !== 1'b1) begin bad++; $display("FAIL single_count got=%0d/%b exp=1/1", obs_cnt, obs_hit); end
`ifdef PSC_POS_EN
        total++; if (obs_pos !== 3'd3) begin bad++; $display("FAIL single_pos got=%0d exp=3", obs_pos); end
`endif
    endtask

    task automatic test_multi_hits;
        logic [W-1:0] words [3] = '{8'h88, 8'h10, 8'hFF};
        int ecnt [3] = '{2, 1, 0};
        int epos [3] = '{3, 6, 0};
        for (int i = 0; i < 3; i++) begin
            run_word(words[i], 0);
            $display("word=%h count=%0d hit=%b pos=%0d sat=%0d", words[i], obs_cnt, obs_hit, obs_pos, obs_scnt);
            total++; if (obs_cnt !== 4'(ecnt[i]) || obs_hit !== (ecnt[i] != 0)) begin bad++; $display("FAIL multi_count word=%h got=%0d/%b exp=%0d", words[i], obs_cnt, obs_hit, ecnt[i]); end
            total++; if (obs_scnt !== 1'(ecnt[i] != 0) || obs_shit !== (ecnt[i] != 0)) begin bad++; $display("FAIL saturate word=%h got=%0d/%b exp=%0d", words[i], obs_scnt, obs_shit, ecnt[i] != 0); end
`ifdef PSC_POS_EN
            total++; if (obs_pos !== PW'(epos[i])) begin bad++; $display("FAIL multi_pos word=%h got=%0d exp=%0d", words[i], obs_pos, epos[i]); end
`else
            if (epos[i] < 0) $display("unreachable");
`endif
        end
    endtask

    task automatic test_backpressure;
        run_word(8'h88, 5);
        $display("word=88 hold=5 stable=%b ready_after=%b", obs_bp_ok, obs_rdy_after);
        total++; if (obs_bp_ok !== 1'b1) begin bad++; $display("FAIL bp_stable got=%b exp=1", obs_bp_ok); end
        total++; if (obs_rdy_after !== 1'b1 || obs_ov_after !== 1'b0) begin bad++; $display("FAIL bp_release got=%b/%b exp=1/0", obs_rdy_after, obs_ov_after); end
        total++; if (obs_cnt !== 4'd2) begin bad++; $display("FAIL bp_count got=%0d exp=2", obs_cnt); end
    endtask

    task automatic test_cross_word;
        run_word(8'h01, 0);
        total++; if (obs_cnt !== 4'd0) begin bad++; $display("FAIL cross_first got=%0d exp=0", obs_cnt); end
        run_word(8'h00, 0);
        $display("word=00 after 01 count=%0d", obs_cnt);
        total++; if (obs_cnt !== 4'd0 || obs_hit !== 1'b0) begin bad++; $display("FAIL cross_second got=%0d/%b exp=0/0", obs_cnt, obs_hit); end
    endtask

    task automatic test_reset_mid;
        logic seen;
        in_valid = 1'b1; in_data = 8'h80; out_ready = 1'b1;
        @(posedge clock); #1; in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1; reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        total++; if (in_ready !== 1'b1 || det_reset !== 1'b1) begin bad++; $display("FAIL midreset_state got=%b/%b exp=1/1", in_ready, det_reset); end
        total++; if (out_valid !== 1'b0 || out_count !== 4'd0) begin bad++; $display("FAIL midreset_out got=%b/%0d exp=0/0", out_valid, out_count); end
        seen = 1'b0;
        repeat (W + 4) begin
            if (out_valid) seen = 1'b1;
            @(posedge clock); #1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_no_output got=%b exp=0", seen); end
        run_word(8'h80, 0);
        $display("word=80 after midreset count=%0d", obs_cnt);
        total++; if (obs_cnt !== 4'd1) begin bad++; $display("FAIL midreset_next got=%0d exp=1", obs_cnt); end
    endtask

    task automatic test_back_to_back;
        int a0;
        run_word(8'h88, 0);
        a0 = obs_acc;
        run_word(8'h80, 0);
        $display("back_to_back interval=%0d count=%0d", obs_acc - a0, obs_cnt);
        total++; if (obs_acc - a0 != W + 3) begin bad++; $display("FAIL throughput got=%0d exp=%0d", obs_acc - a0, W + 3); end
        total++; if (obs_cnt !== 4'd1) begin bad++; $display("FAIL b2b_count got=%0d exp=1", obs_cnt); end
    endtask

    task automatic test_random;
        logic [W-1:0] w;
        int e, hold;
        for (int i = 0; i < 60; i++) begin
            w = W'($urandom);
            if (i % 2 == 1) w = w & W'($urandom);
            hold = $urandom_range(0, 2);
            e = ref_hits(w);
            run_word(w, hold);
            $display("rand word=%h hold=%0d count=%0d exp=%0d pos=%0d", w, hold, obs_cnt, e, obs_pos);
            total++; if (obs_cnt !== 4'(e) || obs_hit !== (e != 0)) begin bad++; $display("FAIL rand_count word=%h got=%0d exp=%0d", w, obs_cnt, e); end
            total++; if (obs_scnt !== 1'(e != 0)) begin bad++; $display("FAIL rand_sat word=%h got=%0d exp=%0d", w, obs_scnt, e != 0); end
            total++; if (obs_lat != W + 2 || obs_seq !== w) begin bad++; $display("FAIL rand_shift word=%h lat=%0d seq=%b", w, obs_lat, obs_seq); end
`ifdef PSC_POS_EN
            total++; if (obs_pos !== PW'(ref_first(w)) || obs_spos !== PW'(ref_first(w))) begin bad++; $display("FAIL rand_pos word=%h got=%0d/%0d exp=%0d", w, obs_pos, obs_spos, ref_first(w)); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_multi_hits();
        test_backpressure();
        test_cross_word();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
